// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front-end: PC, imem req/ack, instruction buffer, redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic          fetch_err_q, fetch_err_d;

  logic [31:0]   buf_data_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q   [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          push, pop, misaligned, pending;
  logic [CW-1:0] count_after;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign push        = (state_q == REQ) && imem_ack && !redirect;
  assign count_after = count_q + CW'(push) - CW'(pop);
  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign pending     = imem_req && !imem_ack;

  assign imem_req  = (state_q == REQ) || (state_q == DROP);
  // DROP keeps presenting the abandoned address while fetch_pc already holds the new target
  assign imem_addr = (state_q == DROP) ? hold_addr_q : fetch_pc_q;
  assign instr     = instr_valid ? buf_data_q[rd_ptr_q] : NOP;
  assign instr_pc  = instr_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign fetch_err = fetch_err_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    fetch_err_d = fetch_err_q;
    if (redirect) begin
      fetch_pc_d  = redirect_pc;
      fetch_err_d = misaligned;
      if (pending) begin
        // an unacked request must complete first; a bad target halts after the drain
        state_d = DROP;
        if (state_q == REQ) hold_addr_d = fetch_pc_q;
      end else begin
        state_d = misaligned ? HALT : REQ;
      end
    end else begin
      case (state_q)
        IDLE: if (count_q < DEPTH_C) state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (count_after >= DEPTH_C) state_d = IDLE;
          end
        end
        DROP: if (imem_ack) state_d = fetch_err_q ? HALT : REQ;
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= RESET_PC;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[i] <= NOP;
        buf_pc_q[i]   <= 32'h0;
      end
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= imem_rdata;
        buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_after;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the integer instruction decoder.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words with their PC in a small FIFO and presents them to the decoder with valid/ready.
- Redirects on jump/branch from execute, discarding wrong-path words, and flags misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  32  word address of request, stable while imem_req=1
imem_ack  input  1  request accepted, imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  buffer head valid toward decoder
instr_ready  input  1  decoder consumes head this cycle
instr  output  32  instruction at buffer head (feeds decoder instr)
instr_pc  output  32  PC of instr
redirect  input  1  taken jump/branch, one-cycle pulse
redirect_pc  input  32  new fetch target
fetch_err  output  1  misaligned redirect target, sticky

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n); clk is the only clock.
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, fetch_err=0, buffer empty, state=IDLE, fetch_pc=RESET_PC.
- State machine: IDLE, REQ, DROP, HALT.
  - IDLE: move to REQ when free slots exist (count + outstanding < BUF_DEPTH). The first request appears the first cycle after rst_n deasserts.
  - REQ: imem_req=1, imem_addr=fetch_pc. On ack, push {fetch_pc, imem_rdata} and set fetch_pc+=4.
    - If space remains after this push and any same-cycle pop, stay in REQ; the next address is presented the following cycle, giving 1 word/cycle with zero-wait memory.
    - Otherwise go to IDLE.
  - DROP: entered on redirect while a request is pending without ack. Keep imem_req=1 with the old address until ack, discard the data, then go to REQ at the new fetch_pc.
  - HALT: imem_req=0. Leave only on a redirect with an aligned target.
- Address handling: imem_addr must never change while imem_req=1 and ack=0. fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC+4=0).
- Buffer: circular FIFO with count field.
  - instr_valid = count!=0.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - A push is never attempted when full (guaranteed by the request gating).
  - Data enters the buffer registered: ack in cycle N → instr_valid in N+1.
- Redirect (highest priority):
  - Flush the buffer (count=0, instr_valid=0 next cycle); any same-cycle pop is ignored.
  - Set fetch_pc=redirect_pc.
  - If ack coincides with redirect, drop that data and go to REQ.
  - If redirect_pc[1:0]!=0, set fetch_err=1 and enter HALT; fetch_err clears on the next aligned redirect.
  - A redirect while in DROP updates the target and stays in DROP.
- Stall: instr_ready=0 holds the head stable (instr, instr_pc unchanged) and fetching stops once the buffer is full.
- Reset mid-handshake: all state clears immediately and the pending request is abandoned. Memory must tolerate the dropped req.

Test Plan:
- Reset release, RESET_PC=0, imem_ack tied 1, memory word[i]=i, instr_ready=1 → imem_addr 0,4,8,... on consecutive cycles; instr_valid from cycle 2; instr_pc 0,4,8 with instr 0,1,2.
- instr_ready=0 for 5 cycles → exactly BUF_DEPTH=2 words buffered, imem_req=0; head stays pc=0; release gives pc 0,4,8 with no gap or duplicate.
- Memory acks 3 cycles after req; redirect to 0x100 in cycle 1 of wait → imem_addr held at the old value until ack; that word is never presented; next imem_addr=0x100; first instr_pc=0x100.
- Redirect same cycle as ack and as a pop → dropped word absent; buffer empty next cycle; following request at redirect_pc.
- Redirect to 0x102 → fetch_err=1, imem_req=0 persistently; later redirect to 0x200 → fetch_err=0, fetch resumes at 0x200.
- Redirect to 0xFFFF_FFFC → addresses FFFF_FFFC then 0000_0000; rst_n asserted during a pending req → all outputs at reset values in the same cycle.
